regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback.sv | 94 +++++++++
 tb/tb_regfile_writeback.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter: ALU results take priority, load results wait
// in a small FIFO, and a pending scoreboard flags RAW hazards on outstanding loads.
module regfile_writeback #(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [WORD_LENGTH-1:0]   alu_data,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_rd,
  input  logic [WORD_LENGTH-1:0]   mem_data,
  output logic                     mem_ready,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic [4:0]               chk_rs1,
  input  logic [4:0]               chk_rs2,
  output logic                     stall,
  output logic                     wb_enable,
  output logic [4:0]               wb_add,
  output logic [WORD_LENGTH-1:0]   wb_data,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]             rd;
    logic [WORD_LENGTH-1:0] data;
  } entry_t;

  entry_t           buf_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      pending;
  logic [31:0]      pending_nxt;
  entry_t           head;
  logic             push;
  logic             pop;

  assign head = buf_q[rd_ptr];

  always_comb begin
    mem_ready = (fifo_count < CNT_W'(DEPTH));
    push      = mem_valid & mem_ready;
    pop       = ~alu_valid & (fifo_count != '0);
    stall     = pending[chk_rs1] | pending[chk_rs2];
  end

  // Set wins over clear, so a reissue to the same rd stays pending.
  always_comb begin
    pending_nxt = pending;
    if (pop) pending_nxt[head.rd] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (rst && push) buf_q[wr_ptr] <= '{rd: mem_rd, data: mem_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      pending    <= '0;
      wb_enable  <= 1'b0;
      wb_add     <= '0;
      wb_data    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      pending    <= pending_nxt;
      if (alu_valid) begin
        wb_enable <= (alu_rd != 5'd0);
        wb_add    <= alu_rd;
        wb_data   <= alu_data;
      end else if (pop) begin
        wb_enable <= (head.rd != 5'd0);
        wb_add    <= head.rd;
        wb_data   <= head.data;
      end else begin
        wb_enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_regfile_writeback;

  localparam int unsigned WL    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid, issue_valid;
  logic [4:0]    alu_rd, mem_rd, issue_rd, chk_rs1, chk_rs2;
  logic [WL-1:0] alu_data, mem_data;
  logic          mem_ready, stall, wb_enable;
  logic [4:0]    wb_add;
  logic [WL-1:0] wb_data;
  logic [$clog2(DEPTH):0] fifo_count;

  regfile_writeback #(.WORD_LENGTH(WL), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .stall(stall),
    .wb_enable(wb_enable), .wb_add(wb_add), .wb_data(wb_data),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    rd;
    logic [WL-1:0] data;
  } ent_t;

  ent_t          q[$];
  bit            pend[32];
  logic          m_en;
  logic [4:0]    m_add;
  logic [WL-1:0] m_data;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [WL-1:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [WL-1:0] md,
                       input logic iv, input logic [4:0] ir);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
    issue_valid = iv; issue_rd = ir;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic cyc();
    ent_t e;
    bit   accept;
    #1;
    check("mem_ready", 64'(mem_ready), 64'(q.size() < DEPTH));
    check("fifo_count", 64'(fifo_count), 64'(q.size()));
    check("stall", 64'(stall), 64'(pend[chk_rs1] | pend[chk_rs2]));
    accept = mem_valid && (q.size() < DEPTH);
    @(posedge clk);
    if (!rst) begin
      q.delete();
      foreach (pend[i]) pend[i] = 0;
      m_en = 1'b0; m_add = '0; m_data = '0;
    end else begin
      if (alu_valid) begin
        m_en = (alu_rd != 0); m_add = alu_rd; m_data = alu_data;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        pend[e.rd] = 0;
        m_en = (e.rd != 0); m_add = e.rd; m_data = e.data;
      end else begin
        m_en = 1'b0;
      end
      if (accept) q.push_back('{rd: mem_rd, data: mem_data});
      if (issue_valid && issue_rd != 0) pend[issue_rd] = 1;
      pend[0] = 0;
    end
    #1;
    check("wb_enable", 64'(wb_enable), 64'(m_en));
    check("wb_add", 64'(wb_add), 64'(m_add));
    check("wb_data", 64'(wb_data), 64'(m_data));
  endtask

  initial begin
    m_en = 1'b0; m_add = '0; m_data = '0;
    chk_rs1 = 5'd0; chk_rs2 = 5'd0;
    idle();
    rst = 1'b0;
    @(negedge clk);
    cyc();
    cyc();
    rst = 1'b1;
    check("reset_mem_ready", 64'(mem_ready), 64'd1);
    check("reset_count", 64'(fifo_count), 64'd0);

    // ALU single-cycle writeback
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    cyc();
    check("alu_en", 64'(wb_enable), 64'd1);
    check("alu_add", 64'(wb_add), 64'd5);
    check("alu_data", 64'(wb_data), 64'h1234);
    idle();
    cyc();
    check("alu_single_cycle", 64'(wb_enable), 64'd0);

    // Load hazard held behind an ALU stream
    chk_rs1 = 5'd7;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd7);
    cyc();
    check("haz_stall_issue", 64'(stall), 64'd1);
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'hAA, 1'b0, 5'd0);
    cyc();
    mem_valid = 1'b0;
    alu_rd = 5'd2; cyc();
    alu_rd = 5'd3; cyc();
    check("haz_stall_hold", 64'(stall), 64'd1);
    idle();
    cyc();
    check("haz_load_add", 64'(wb_add), 64'd7);
    check("haz_load_data", 64'(wb_data), 64'hAA);
    #1 check("haz_stall_clear", 64'(stall), 64'd0);
    chk_rs1 = 5'd0;

    // FIFO fill to full while ALU has priority, then drain in order
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1'b1, 5'(20 + i), 32'(i), 1'b1, 5'(10 + i), 32'hB00 + 32'(i), 1'b0, 5'd0);
      if (i == DEPTH) begin
        #1;
        check("full_count", 64'(fifo_count), 64'(DEPTH));
        check("full_ready", 64'(mem_ready), 64'd0);
      end
      cyc();
    end
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      cyc();
      check("drain_order", 64'(wb_add), 64'(10 + i));
    end
    cyc();
    check("drain_empty", 64'(fifo_count), 64'd0);

    // rd==0 never writes but still consumes
    drive(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0);
    cyc();
    check("r0_alu_en", 64'(wb_enable), 64'd0);
    idle();
    cyc();
    check("r0_mem_en", 64'(wb_enable), 64'd0);
    check("r0_mem_pop", 64'(fifo_count), 64'd0);

    // Reset discards buffered entries and pending bits
    chk_rs1 = 5'd9;
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC0, 1'b1, 5'd9);
    for (int i = 0; i < 3; i++) begin
      mem_rd = 5'(12 + i);
      cyc();
      issue_valid = 1'b0;
    end
    check("pre_rst_count", 64'(fifo_count), 64'd3);
    rst = 1'b0;
    drive(1'b1, 5'd4, 32'h4, 1'b1, 5'd15, 32'hD0, 1'b1, 5'd9);
    cyc();
    rst = 1'b1;
    idle();
    #1;
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_wb_en", 64'(wb_enable), 64'd0);
    check("rst_ready", 64'(mem_ready), 64'd1);
    cyc();
    chk_rs1 = 5'd0;

    // Issue and pop of the same rd in one cycle keeps it pending
    chk_rs2 = 5'd3;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd3);
    cyc();
    drive(1'b1, 5'd8, 32'h8, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
    cyc();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd3);
    cyc();
    check("same_rd_pop", 64'(wb_add), 64'd3);
    idle();
    #1 check("same_rd_stall", 64'(stall), 64'd1);
    cyc();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      drive(1'($urandom_range(0, 2) == 0), 5'($urandom), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom), $urandom,
            1'($urandom_range(0, 3) == 0), 5'($urandom));
      chk_rs1 = 5'($urandom);
      chk_rs2 = 5'($urandom);
      cyc();
    end
    rst = 1'b1;
    idle();
    for (int n = 0; n < DEPTH + 2; n++) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
